// File: rtl/sw_panel_ctrl.sv
// rtl/sw_panel_ctrl.sv - stopwatch front-panel controller: debounced commands, run/pause/edit FSM, lap view select
// Optional PANEL_BLINK_EN builds the edit-digit blink generator.
module sw_panel_ctrl #(
    parameter logic [15:0] DEB_CYCLES   = 16'd50000,
    parameter logic [31:0] LAP_HOLD     = 32'd300000000,
    parameter logic [31:0] BLINK_CYCLES = 32'd25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_lap,
    input  logic       btn_clr,
    input  logic       btn_set,
    input  logic       btn_inc,
    output logic       start,
    output logic       stop,
    output logic       lap,
    output logic       clr,
    output logic       load,
    output logic [3:0] load_ms_hr,
    output logic [3:0] load_ls_hr,
    output logic [3:0] load_ms_min,
    output logic [3:0] load_ls_min,
    output logic [1:0] ctrl_state,
    output logic [1:0] edit_digit,
    output logic       disp_sel,
    output logic       edit_blink
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_EDIT  = 2'd3
    } state_t;

    // Button lanes: 0=ss 1=lap 2=clr 3=set 4=inc
    logic [4:0]  raw;
    logic [4:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [4:0]  deb_q, deb_d, deb_prev_q, deb_prev_d, ev_q, ev_d;
    logic [15:0] cnt_q [5];
    logic [15:0] cnt_d [5];

    assign raw = {btn_inc, btn_set, btn_clr, btn_lap, btn_ss};

    always_comb begin
        sync1_d    = raw;
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        deb_prev_d = deb_q;
        ev_d       = deb_q & ~deb_prev_q;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = 16'd0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_CYCLES - 16'd1) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            ev_q       <= '0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            ev_q       <= ev_d;
            for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Only the highest-priority event of a cycle survives: clr > set > ss > lap > inc
    logic e_clr, e_set, e_ss, e_lap, e_inc;
    assign e_clr = ev_q[2];
    assign e_set = ev_q[3] & ~ev_q[2];
    assign e_ss  = ev_q[0] & ~ev_q[2] & ~ev_q[3];
    assign e_lap = ev_q[1] & ~ev_q[0] & ~ev_q[2] & ~ev_q[3];
    assign e_inc = ev_q[4] & ~ev_q[1] & ~ev_q[0] & ~ev_q[2] & ~ev_q[3];

    state_t      state_q, state_d, ret_q, ret_d;
    logic        start_q, start_d, stop_q, stop_d, lap_q, lap_d;
    logic        clr_q, clr_d, load_q, load_d;
    logic        disp_q, disp_d, hold_q, hold_d;
    logic [31:0] lap_cnt_q, lap_cnt_d;
    logic [1:0]  digit_q, digit_d;
    logic [3:0]  e_mshr_q, e_mshr_d, e_lshr_q, e_lshr_d;
    logic [3:0]  e_mmin_q, e_mmin_d, e_lmin_q, e_lmin_d;
    logic [3:0]  ld_mshr_q, ld_mshr_d, ld_lshr_q, ld_lshr_d;
    logic [3:0]  ld_mmin_q, ld_mmin_d, ld_lmin_q, ld_lmin_d;
    logic        enter_edit;

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        lap_d      = 1'b0;
        clr_d      = 1'b0;
        load_d     = 1'b0;
        disp_d     = disp_q;
        hold_d     = hold_q;
        lap_cnt_d  = lap_cnt_q;
        digit_d    = digit_q;
        e_mshr_d   = e_mshr_q;
        e_lshr_d   = e_lshr_q;
        e_mmin_d   = e_mmin_q;
        e_lmin_d   = e_lmin_q;
        ld_mshr_d  = ld_mshr_q;
        ld_lshr_d  = ld_lshr_q;
        ld_mmin_d  = ld_mmin_q;
        ld_lmin_d  = ld_lmin_q;
        enter_edit = 1'b0;

        // Lap-view hold timer; a lap event below overrides an expiry in the same cycle
        if (hold_q) begin
            if (lap_cnt_q == 32'd0) begin
                hold_d = 1'b0;
                disp_d = 1'b0;
            end else begin
                lap_cnt_d = lap_cnt_q - 32'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (e_clr) begin
                    clr_d = 1'b1;
                end else if (e_set) begin
                    enter_edit = 1'b1;
                end else if (e_ss) begin
                    start_d = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (e_clr) begin
                    clr_d   = 1'b1;
                    disp_d  = 1'b0;
                    hold_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (e_ss) begin
                    stop_d  = 1'b1;
                    state_d = ST_PAUSE;
                end else if (e_lap) begin
                    lap_d     = 1'b1;
                    disp_d    = 1'b1;
                    hold_d    = 1'b1;
                    lap_cnt_d = LAP_HOLD - 32'd1;
                end
            end
            ST_PAUSE: begin
                if (e_clr) begin
                    clr_d   = 1'b1;
                    disp_d  = 1'b0;
                    hold_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (e_set) begin
                    enter_edit = 1'b1;
                end else if (e_ss) begin
                    start_d = 1'b1;
                    state_d = ST_RUN;
                end else if (e_lap) begin
                    disp_d = ~disp_q;
                    hold_d = 1'b0;
                end
            end
            default: begin
                if (e_clr) begin
                    state_d = ret_q;
                    digit_d = 2'd0;
                end else if (e_set) begin
                    if (digit_q == 2'd3) begin
                        load_d    = 1'b1;
                        ld_mshr_d = e_mshr_q;
                        ld_lshr_d = e_lshr_q;
                        ld_mmin_d = e_mmin_q;
                        ld_lmin_d = e_lmin_q;
                        state_d   = ST_PAUSE;
                        digit_d   = 2'd0;
                    end else begin
                        digit_d = digit_q + 2'd1;
                    end
                end else if (e_inc) begin
                    case (digit_q)
                        2'd0: begin
                            if (e_mshr_q >= 4'd2) begin
                                e_mshr_d = 4'd0;
                            end else begin
                                e_mshr_d = e_mshr_q + 4'd1;
                                if (e_mshr_q == 4'd1 && e_lshr_q > 4'd3) e_lshr_d = 4'd3;
                            end
                        end
                        2'd1: begin
                            if ((e_mshr_q == 4'd2 && e_lshr_q >= 4'd3) || e_lshr_q >= 4'd9)
                                e_lshr_d = 4'd0;
                            else
                                e_lshr_d = e_lshr_q + 4'd1;
                        end
                        2'd2: e_mmin_d = (e_mmin_q >= 4'd5) ? 4'd0 : e_mmin_q + 4'd1;
                        default: e_lmin_d = (e_lmin_q >= 4'd9) ? 4'd0 : e_lmin_q + 4'd1;
                    endcase
                end
            end
        endcase

        if (enter_edit) begin
            state_d  = ST_EDIT;
            ret_d    = state_q;
            digit_d  = 2'd0;
            e_mshr_d = 4'd0;
            e_lshr_d = 4'd0;
            e_mmin_d = 4'd0;
            e_lmin_d = 4'd0;
            disp_d   = 1'b0;
            hold_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ret_q     <= ST_IDLE;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            lap_q     <= 1'b0;
            clr_q     <= 1'b0;
            load_q    <= 1'b0;
            disp_q    <= 1'b0;
            hold_q    <= 1'b0;
            lap_cnt_q <= '0;
            digit_q   <= '0;
            e_mshr_q  <= '0;
            e_lshr_q  <= '0;
            e_mmin_q  <= '0;
            e_lmin_q  <= '0;
            ld_mshr_q <= '0;
            ld_lshr_q <= '0;
            ld_mmin_q <= '0;
            ld_lmin_q <= '0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
            lap_q     <= lap_d;
            clr_q     <= clr_d;
            load_q    <= load_d;
            disp_q    <= disp_d;
            hold_q    <= hold_d;
            lap_cnt_q <= lap_cnt_d;
            digit_q   <= digit_d;
            e_mshr_q  <= e_mshr_d;
            e_lshr_q  <= e_lshr_d;
            e_mmin_q  <= e_mmin_d;
            e_lmin_q  <= e_lmin_d;
            ld_mshr_q <= ld_mshr_d;
            ld_lshr_q <= ld_lshr_d;
            ld_mmin_q <= ld_mmin_d;
            ld_lmin_q <= ld_lmin_d;
        end
    end

`ifdef PANEL_BLINK_EN
    logic        blink_q, blink_d;
    logic [31:0] blink_cnt_q, blink_cnt_d;

    always_comb begin
        blink_d     = 1'b0;
        blink_cnt_d = 32'd0;
        if (state_d == ST_EDIT) begin
            if (state_q != ST_EDIT || e_set || e_inc) begin
                blink_d = 1'b1;
            end else if (blink_cnt_q == BLINK_CYCLES - 32'd1) begin
                blink_d = ~blink_q;
            end else begin
                blink_d     = blink_q;
                blink_cnt_d = blink_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign edit_blink = blink_q;
`else
    logic unused_blink;
    assign unused_blink = ^BLINK_CYCLES;
    assign edit_blink   = 1'b0;
`endif

    assign start       = start_q;
    assign stop        = stop_q;
    assign lap         = lap_q;
    assign clr         = clr_q;
    assign load        = load_q;
    assign load_ms_hr  = ld_mshr_q;
    assign load_ls_hr  = ld_lshr_q;
    assign load_ms_min = ld_mmin_q;
    assign load_ls_min = ld_lmin_q;
    assign ctrl_state  = state_q;
    assign edit_digit  = digit_q;
    assign disp_sel    = disp_q;

endmodule

// File: doc/sw_panel_ctrl.md
Name: sw_panel_ctrl

Overview:
Front-panel controller for the BCD stopwatch datapath. It turns five raw push-buttons into clean single-cycle start/stop/lap/clr/load commands. It tracks run/pause mode and runs a digit-by-digit HH:MM entry sequence that produces the load value. It also drives the display-source select (live count vs lap) used by the 7-segment driver.

Parameters:
DEB_CYCLES, 16'd50000, consecutive stable cycles before a debounced level changes (min 2)
LAP_HOLD, 32'd300000000, cycles disp_sel stays at lap view after a lap command
BLINK_CYCLES, 32'd25000000, half-period of edit_blink (used only with PANEL_BLINK_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
btn_ss  in  1  raw start/stop button, asynchronous
btn_lap  in  1  raw lap button
btn_clr  in  1  raw clear button
btn_set  in  1  raw set/next-digit button
btn_inc  in  1  raw increment button
start  out  1  one-cycle start command to stopwatch
stop  out  1  one-cycle stop command
lap  out  1  one-cycle lap command
clr  out  1  one-cycle clear command
load  out  1  one-cycle load command
load_ms_hr  out  4  BCD load digit, hours tens
load_ls_hr  out  4  BCD load digit, hours units
load_ms_min  out  4  BCD load digit, minutes tens
load_ls_min  out  4  BCD load digit, minutes units
ctrl_state  out  2  0=IDLE 1=RUN 2=PAUSE 3=EDIT
edit_digit  out  2  digit under edit, 0=ms_hr .. 3=ls_min
disp_sel  out  1  0=show count, 1=show lap
edit_blink  out  1  blink enable for the digit under edit

Behaviour:
- Reset: all outputs 0, ctrl_state=IDLE. Debouncers, timers and sync flops are cleared. Reset mid-EDIT discards the entry and emits no pulse.
- Per button: 2-flop synchronizer, then a debouncer. The debounced level flips only after DEB_CYCLES consecutive synchronized cycles that differ from it. Any matching cycle restarts the count. A rising edge of the debounced level is a one-cycle event.
- Latency: a raw level sampled high at edge N with no bounce gives the command pulse high after edge N+DEB_CYCLES+3.
- Command outputs are registered. At most one is high in any cycle. Each is high for exactly one cycle per press; holding a button does not repeat.
- Event priority within one cycle: clr > set > ss > lap > inc. Lower-priority events in that cycle are dropped, not queued.
- IDLE:
  - ss -> start pulse, go to RUN.
  - set -> go to EDIT.
  - clr -> clr pulse, stay in IDLE.
  - lap and inc are ignored.
- RUN:
  - ss -> stop pulse, go to PAUSE.
  - lap -> lap pulse, disp_sel=1, hold timer loaded with LAP_HOLD. disp_sel returns to 0 when the timer expires. A lap during the hold reloads the timer.
  - clr -> clr pulse, disp_sel=0, go to IDLE.
  - set and inc are ignored.
- PAUSE:
  - ss -> start pulse, go to RUN.
  - clr -> clr pulse, disp_sel=0, go to IDLE.
  - set -> go to EDIT.
  - lap -> toggle disp_sel, no pulse, no timer.
- EDIT entry: edit registers cleared to 0, edit_digit=0, disp_sel=0. The entry state (IDLE or PAUSE) is remembered.
- EDIT inc: increments the current digit with wrap.
  - ms_hr wraps 2->0.
  - ls_hr wraps 9->0, or 3->0 when ms_hr==2.
  - ms_min wraps 5->0.
  - ls_min wraps 9->0.
  - Incrementing ms_hr to 2 while ls_hr>3 forces ls_hr=3.
- EDIT set: advances edit_digit 0->1->2->3. Set on digit 3 copies the edit registers to load_* in the same cycle load pulses, then goes to PAUSE.
- EDIT clr: abort, no pulse, return to the entry state; load_* unchanged.
- EDIT ss and lap: ignored.
- load_* change only on a load pulse and hold their value otherwise.
- edit_digit reads 0 outside EDIT.

Optional Feature:
PANEL_BLINK_EN:
- Defined: in EDIT, edit_blink toggles every BLINK_CYCLES cycles, starting at 1 on EDIT entry. Each inc or set restarts the phase at 1. Outside EDIT it is 0.
- Undefined: edit_blink is tied 0, no blink counter is built, and BLINK_CYCLES is unused.

Test Plan:
All scenarios use DEB_CYCLES=4, LAP_HOLD=8.
- Reset: rst high 3 cycles, then low -> all outputs 0, ctrl_state=0. A 2-cycle btn_ss glitch -> no pulse.
- btn_ss held 20 cycles from edge N -> single start pulse at edge N+7, ctrl_state=1. Second press -> single stop pulse, ctrl_state=2. Third press -> start, ctrl_state=1.
- In RUN, lap press -> one lap pulse and disp_sel=1 for 8 cycles. A second lap 5 cycles later -> second pulse, disp_sel stays 1 for 8 cycles after it.
- From IDLE:
  - set, inc x1, set, inc x2, set, inc x5, set, inc x8, set -> load pulse with 1,2,5,8; ctrl_state=2.
  - Repeat with ms_hr=2 and ls_hr inc x5 -> ls_hr=1 (wrap at 3).
- In RUN, btn_clr and btn_ss rise in the same cycle -> only clr pulses, ctrl_state=0.
- In EDIT, clr -> no pulse, return to the entry state, load_* unchanged. rst mid-EDIT -> all outputs 0.
